hazard_forward_ctrl: RTL and testbench

- Control block for the ID->EX boundary of the 5-stage pipeline. It consumes the EX-stage control and address outputs of the ID/EX register, plus MEM-stage write-back info.
- Drives back into the front end: operand forwarding selects for the ID-stage operand muxes, load-use stall, ID/EX bubble insertion, IF/ID flush on taken branch, and flag forwarding for B.cond.
- Keeps a small FSM and saturating event counters for debug.

---
 rtl/hazard_forward_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_ctrl
// Brief    : ID->EX hazard control: operand/flag forwarding, load-use stall,
//            taken-branch flush and saturating debug event counters.
// Revision : 1.0
// ============================================================================
module hazard_forward_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IDRn,
    input  logic [4:0]       IDRm,
    input  logic             IDUsesRn,
    input  logic             IDUsesRm,
    input  logic             IDIsBCond,
    input  logic             IDBranchTaken,
    input  logic [4:0]       EXAddressW,
    input  logic             EXRegWrite,
    input  logic             EXMemRead,
    input  logic             EXFlagWrite,
    input  logic [4:0]       MEMAddressW,
    input  logic             MEMRegWrite,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic             FlagFwd,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [4:0]       c_xzr     = 5'd31;
    localparam logic [1:0]       c_sel_rf  = 2'b00;
    localparam logic [1:0]       c_sel_ex  = 2'b01;
    localparam logic [1:0]       c_sel_mem = 2'b10;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic       w_rn_used;
    logic       w_rm_used;
    logic       w_ex_alu_wr;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_load_use;
    logic       w_stall_now;

    // XZR reads are constant zero, so they can never depend on an older write
    assign w_rn_used   = IDUsesRn && (IDRn != c_xzr);
    assign w_rm_used   = IDUsesRm && (IDRm != c_xzr);
    assign w_ex_alu_wr = EXRegWrite && !EXMemRead;

    always_comb begin
        w_fwd_a = c_sel_rf;
        if (w_rn_used && w_ex_alu_wr && (EXAddressW == IDRn))
            w_fwd_a = c_sel_ex;
        else if (w_rn_used && MEMRegWrite && (MEMAddressW == IDRn))
            w_fwd_a = c_sel_mem;
    end

    always_comb begin
        w_fwd_b = c_sel_rf;
        if (w_rm_used && w_ex_alu_wr && (EXAddressW == IDRm))
            w_fwd_b = c_sel_ex;
        else if (w_rm_used && MEMRegWrite && (MEMAddressW == IDRm))
            w_fwd_b = c_sel_mem;
    end

    assign w_load_use = EXMemRead && EXRegWrite &&
                        ((w_rn_used && (EXAddressW == IDRn)) ||
                         (w_rm_used && (EXAddressW == IDRm)));

    // In STALL the load has moved to MEM, so the hazard is not re-evaluated
    assign w_stall_now = (r_state == RUN) && w_load_use;

    always_comb begin
        w_next_state = RUN;
        FwdA         = w_fwd_a;
        FwdB         = w_fwd_b;
        FlagFwd      = IDIsBCond && EXFlagWrite;
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        IFIDFlush    = IDBranchTaken;
        IDEXBubble   = 1'b0;
        if (!reset) begin
            FwdA       = c_sel_rf;
            FwdB       = c_sel_rf;
            FlagFwd    = 1'b0;
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (w_stall_now) begin
            // Stall beats a simultaneous taken branch; it re-resolves next cycle
            w_next_state = STALL;
            FwdA         = c_sel_rf;
            FwdB         = c_sel_rf;
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            IFIDFlush    = 1'b0;
            IDEXBubble   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_stall_now && (r_stall_cnt != c_cnt_max))
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            if (IFIDFlush && (r_flush_cnt != c_cnt_max))
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
        end
    end

    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_forward_ctrl
// Brief    : Scoreboard bench for hazard_forward_ctrl with a pipeline-level model.
// Revision : 1.0
// ============================================================================
module tb_hazard_forward_ctrl;

    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [1:0]       fwda;
        logic [1:0]       fwdb;
        logic             flag;
        logic             pcw;
        logic             ifidw;
        logic             flush;
        logic             bubble;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       rn, rm, exa, mema;
    logic             usesrn, usesrm, bcond, taken, exrw, exmr, exfw, memrw;
    logic [1:0]       FwdA, FwdB;
    logic             FlagFwd, PCWrite, IFIDWrite, IFIDFlush, IDEXBubble;
    logic [CNT_W-1:0] StallCount, FlushCount;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   ncyc  = 0;

    // Model state: whether the previous cycle already stalled for the load now in MEM
    bit   m_prev_stall = 0;
    int   m_sc = 0;
    int   m_fc = 0;
    bit   m_stall;
    bit   m_flush;

    hazard_forward_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(rst_n),
        .IDRn(rn), .IDRm(rm), .IDUsesRn(usesrn), .IDUsesRm(usesrm),
        .IDIsBCond(bcond), .IDBranchTaken(taken),
        .EXAddressW(exa), .EXRegWrite(exrw), .EXMemRead(exmr), .EXFlagWrite(exfw),
        .MEMAddressW(mema), .MEMRegWrite(memrw),
        .FwdA(FwdA), .FwdB(FwdB), .FlagFwd(FlagFwd), .PCWrite(PCWrite),
        .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXBubble(IDEXBubble),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] src_sel(input logic [4:0] src, input logic used);
        if (!used || src == 5'd31) return 2'd0;
        if (exrw && !exmr && exa == src) return 2'd1;
        if (memrw && mema == src) return 2'd2;
        return 2'd0;
    endfunction

    // Compute this cycle's expected response, queue it, then advance the model over the edge
    task automatic step();
        exp_t e;
        bit   a_dep, b_dep;
        a_dep   = usesrn && rn != 5'd31 && exa == rn;
        b_dep   = usesrm && rm != 5'd31 && exa == rm;
        m_stall = rst_n && !m_prev_stall && exmr && exrw && (a_dep || b_dep);
        m_flush = !rst_n || (!m_stall && taken);
        e.sc     = m_sc[CNT_W-1:0];
        e.fc     = m_fc[CNT_W-1:0];
        e.flush  = m_flush;
        if (!rst_n) begin
            e.fwda = 0; e.fwdb = 0; e.flag = 0;
            e.pcw = 0; e.ifidw = 0; e.bubble = 1;
        end else begin
            e.fwda   = m_stall ? 2'd0 : src_sel(rn, usesrn);
            e.fwdb   = m_stall ? 2'd0 : src_sel(rm, usesrm);
            e.flag   = bcond && exfw;
            e.pcw    = !m_stall;
            e.ifidw  = !m_stall;
            e.bubble = m_stall;
        end
        q.push_back(e);
        @(posedge clk);
        if (!rst_n) begin
            m_prev_stall = 0; m_sc = 0; m_fc = 0;
        end else begin
            m_prev_stall = m_stall;
            if (m_stall) m_sc = (m_sc + 1 > CMAX) ? CMAX : m_sc + 1;
            if (m_flush) m_fc = (m_fc + 1 > CMAX) ? CMAX : m_fc + 1;
        end
        #1;
    endtask

    task automatic idle();
        rst_n = 1; rn = 0; rm = 0; exa = 0; mema = 0;
        usesrn = 0; usesrm = 0; bcond = 0; taken = 0;
        exrw = 0; exmr = 0; exfw = 0; memrw = 0;
    endtask

    task automatic load_use(input bit br);
        idle();
        exmr = 1; exrw = 1; exa = 5; rm = 5; usesrm = 1; taken = br;
    endtask

    function automatic logic [4:0] rnd_reg();
        return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
    endfunction

    always @(negedge clk) begin
        exp_t a, e;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{FwdA, FwdB, FlagFwd, PCWrite, IFIDWrite, IFIDFlush, IDEXBubble,
                  StallCount, FlushCount};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle%0d outputs: got %h expected %h", ncyc, a, e);
            end
            ncyc++;
        end
    end

    initial begin
        idle();
        rst_n = 0;
        @(posedge clk); #1;
        step(); step();
        // ALU forward with EX priority over MEM
        idle(); exrw = 1; exa = 3; memrw = 1; mema = 3; rn = 3; usesrn = 1; step();
        // MEM forward, then XZR never matches
        idle(); memrw = 1; mema = 7; rm = 7; usesrm = 1; step();
        mema = 31; rm = 31; step();
        // Load-use: stall once, then proceed with identical inputs
        load_use(0); step(); step();
        // Load-use coinciding with a taken branch
        load_use(1); step(); step();
        // Flag forwarding
        idle(); bcond = 1; exfw = 1; step();
        exfw = 0; step();
        // Five stall events saturate the 2-bit counter, then reset
        for (int i = 0; i < 5; i++) begin
            load_use(0); step(); idle(); step();
        end
        load_use(0); step();
        rst_n = 0; step();
        idle(); step();
        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            rst_n  = ($urandom_range(0, 49) != 0);
            rn     = rnd_reg(); rm = rnd_reg();
            exa    = rnd_reg(); mema = rnd_reg();
            usesrn = 1'($urandom); usesrm = 1'($urandom);
            bcond  = 1'($urandom); taken = ($urandom_range(0, 3) == 0);
            exrw   = ($urandom_range(0, 3) != 0); exmr = ($urandom_range(0, 2) == 0);
            exfw   = 1'($urandom); memrw = 1'($urandom);
            step();
        end
        @(negedge clk); #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
